// File: rtl/axi_lite_times_table_slave_pkg.sv
// Shared constants, FSM state type and response decode for the times-table slave.
package times_table_pkg;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int A_LSB   = 5;
   localparam int B_LSB   = 2;
   localparam int FIELD_W = 3;
   localparam int PROD_W  = 2 * FIELD_W;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   // Decode error outranks misalignment.
   function automatic logic [1:0] addr_resp(input logic [31:0] addr, input logic [31:0] base);
      if (addr[31:8] != base[31:8]) return RESP_DECERR;
      if (addr[1:0] != 2'b00)       return RESP_SLVERR;
      return RESP_OKAY;
   endfunction
endpackage

// File: rtl/axi_lite_times_table_slave_if.sv
// AXI4-Lite bus bundle for the times-table slave; write channels exist only
// when TIMES_TABLE_WRITE_RESP_EN is defined.
interface axi_lite_times_table_if;
   logic [31:0] s_axi_araddr;
   logic [2:0]  s_axi_arprot;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;
`ifdef TIMES_TABLE_WRITE_RESP_EN
   logic [31:0] s_axi_awaddr;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;

   modport slave (
      input  s_axi_araddr, s_axi_arprot, s_axi_arvalid, s_axi_rready,
      output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
      input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
      output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid
   );
   modport master (
      output s_axi_araddr, s_axi_arprot, s_axi_arvalid, s_axi_rready,
      input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid,
      output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready,
      input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid
   );
`else
   modport slave (
      input  s_axi_araddr, s_axi_arprot, s_axi_arvalid, s_axi_rready,
      output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
   );
   modport master (
      output s_axi_araddr, s_axi_arprot, s_axi_arvalid, s_axi_rready,
      input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
   );
`endif
endinterface

// File: rtl/axi_lite_times_table_slave_rom.sv
// Combinational 3x3-bit unsigned multiplier standing in for the table memory.
module times_table_rom
   import times_table_pkg::*;
(
   input  logic [FIELD_W-1:0] i_a,
   input  logic [FIELD_W-1:0] i_b,
   output logic [PROD_W-1:0]  o_prod
);
   assign o_prod = {{(PROD_W-FIELD_W){1'b0}}, i_a} * {{(PROD_W-FIELD_W){1'b0}}, i_b};
endmodule

// File: rtl/axi_lite_times_table_slave.sv
// AXI4-Lite read-only 8x8 times table with LATENCY-cycle response delay.
// Define TIMES_TABLE_WRITE_RESP_EN to add a write path that always answers SLVERR.
module axi_lite_times_table_slave
   import times_table_pkg::*;
#(
   parameter int          LATENCY   = 1,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   axi_lite_times_table_if.slave  bus
);
   if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("axi_lite_times_table_slave: LATENCY must be in 1..4");
   end

   localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

   state_t               r_state;
   logic                 r_arready;
   logic                 r_rvalid;
   logic [31:0]          r_rdata;
   logic [1:0]           r_rresp;
   logic [1:0]           r_cnt;
   logic [FIELD_W-1:0]   r_a;
   logic [FIELD_W-1:0]   r_b;
   logic [1:0]           r_resp;
   logic [PROD_W-1:0]    w_prod;
   logic [1:0]           w_ar_resp;

   assign w_ar_resp = addr_resp(bus.s_axi_araddr, BASE_ADDR);

   times_table_rom u_rom (
      .i_a    (r_a),
      .i_b    (r_b),
      .o_prod (w_prod)
   );

   // Response class is decided at capture so only a, b and 2 bits are held.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
         r_cnt     <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_resp    <= RESP_OKAY;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_arready && bus.s_axi_arvalid) begin
                  r_arready <= 1'b0;
                  r_a       <= bus.s_axi_araddr[A_LSB +: FIELD_W];
                  r_b       <= bus.s_axi_araddr[B_LSB +: FIELD_W];
                  r_resp    <= w_ar_resp;
                  r_cnt     <= CNT_INIT;
                  r_state   <= WAIT;
               end else begin
                  r_arready <= 1'b1;
               end
            end
            WAIT: begin
               if (r_cnt == 2'd0) begin
                  r_rvalid <= 1'b1;
                  r_rresp  <= r_resp;
                  r_rdata  <= (r_resp == RESP_OKAY) ? {{(32-PROD_W){1'b0}}, w_prod} : '0;
                  r_state  <= RESP;
               end else begin
                  r_cnt <= r_cnt - 2'd1;
               end
            end
            RESP: begin
               if (bus.s_axi_rready) begin
                  r_rvalid  <= 1'b0;
                  r_arready <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.s_axi_arready = r_arready;
   assign bus.s_axi_rvalid  = r_rvalid;
   assign bus.s_axi_rdata   = r_rdata;
   assign bus.s_axi_rresp   = r_rresp;

`ifdef TIMES_TABLE_WRITE_RESP_EN
   logic r_awready;
   logic r_wready;
   logic r_aw_done;
   logic r_w_done;
   logic r_bvalid;

   // AW and W complete independently; B is issued once both have landed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_bvalid  <= 1'b0;
      end else if (r_bvalid) begin
         if (bus.s_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
         end
      end else if (r_aw_done && r_w_done) begin
         r_bvalid <= 1'b1;
      end else begin
         if (r_awready && bus.s_axi_awvalid) begin
            r_aw_done <= 1'b1;
            r_awready <= 1'b0;
         end else if (!r_aw_done) begin
            r_awready <= 1'b1;
         end
         if (r_wready && bus.s_axi_wvalid) begin
            r_w_done <= 1'b1;
            r_wready <= 1'b0;
         end else if (!r_w_done) begin
            r_wready <= 1'b1;
         end
      end
   end

   assign bus.s_axi_awready = r_awready;
   assign bus.s_axi_wready  = r_wready;
   assign bus.s_axi_bvalid  = r_bvalid;
   assign bus.s_axi_bresp   = RESP_SLVERR;

   logic w_unused;
   assign w_unused = ^{bus.s_axi_arprot, bus.s_axi_awaddr, bus.s_axi_wdata, bus.s_axi_wstrb};
`else
   logic w_unused;
   assign w_unused = ^bus.s_axi_arprot;
`endif
endmodule

// File: tb/tb_axi_lite_times_table_slave.sv
// Directed bench: one slave at LATENCY=1 and one at LATENCY=3 share clk/rst.
module tb_axi_lite_times_table_slave;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;

   axi_lite_times_table_if if1 ();
   axi_lite_times_table_if if3 ();

   axi_lite_times_table_slave #(.LATENCY(1), .BASE_ADDR(32'h0000_0000)) dut1 (
      .clk (clk), .rst (rst), .bus (if1.slave)
   );
   axi_lite_times_table_slave #(.LATENCY(3), .BASE_ADDR(32'h0000_0000)) dut3 (
      .clk (clk), .rst (rst), .bus (if3.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic logic g_arready(input int sel);
      return (sel == 3) ? if3.s_axi_arready : if1.s_axi_arready;
   endfunction
   function automatic logic g_rvalid(input int sel);
      return (sel == 3) ? if3.s_axi_rvalid : if1.s_axi_rvalid;
   endfunction
   function automatic logic [31:0] g_rdata(input int sel);
      return (sel == 3) ? if3.s_axi_rdata : if1.s_axi_rdata;
   endfunction
   function automatic logic [1:0] g_rresp(input int sel);
      return (sel == 3) ? if3.s_axi_rresp : if1.s_axi_rresp;
   endfunction

   task automatic drive_ar(input int sel, input logic v, input logic [31:0] a);
      if (sel == 3) begin if3.s_axi_arvalid = v; if3.s_axi_araddr = a; end
      else          begin if1.s_axi_arvalid = v; if1.s_axi_araddr = a; end
   endtask
   task automatic drive_rready(input int sel, input logic v);
      if (sel == 3) if3.s_axi_rready = v;
      else          if1.s_axi_rready = v;
   endtask

   // Issue AR, wait for the handshake, measure latency, hold rready low for
   // `hold` cycles checking stability, then complete.
   task automatic read_chk(input string tag, input int sel, input logic [31:0] addr,
                           input int hold, input int exp_lat,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
      int n;
      int lat;
      @(negedge clk);
      drive_ar(sel, 1'b1, addr);
      drive_rready(sel, hold == 0);
      n = 0;
      while (!g_arready(sel) && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) chk({tag, "_ar_timeout"}, 32'(n), 32'd0);
      @(posedge clk); #1;
      drive_ar(sel, 1'b0, 32'h0);
      chk({tag, "_arready_drop"}, 32'(g_arready(sel)), 32'd0);
      lat = 0;
      while (!g_rvalid(sel) && lat < 20) begin @(posedge clk); #1; lat++; end
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_rdata"}, g_rdata(sel), exp_data);
      chk({tag, "_rresp"}, 32'(g_rresp(sel)), 32'(exp_resp));
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         chk({tag, "_hold_rvalid"}, 32'(g_rvalid(sel)), 32'd1);
         chk({tag, "_hold_rdata"}, g_rdata(sel), exp_data);
         chk({tag, "_hold_rresp"}, 32'(g_rresp(sel)), 32'(exp_resp));
      end
      drive_rready(sel, 1'b1);
      @(posedge clk); #1;
      chk({tag, "_rvalid_done"}, 32'(g_rvalid(sel)), 32'd0);
      chk({tag, "_arready_back"}, 32'(g_arready(sel)), 32'd1);
      drive_rready(sel, 1'b0);
   endtask

   initial begin
      int n;
      n_chk = 0;
      n_pass = 0;
      rst = 1'b1;
      if1.s_axi_araddr = '0; if1.s_axi_arprot = '0; if1.s_axi_arvalid = 1'b0; if1.s_axi_rready = 1'b0;
      if3.s_axi_araddr = '0; if3.s_axi_arprot = '0; if3.s_axi_arvalid = 1'b0; if3.s_axi_rready = 1'b0;
`ifdef TIMES_TABLE_WRITE_RESP_EN
      if1.s_axi_awaddr = '0; if1.s_axi_awvalid = 1'b0; if1.s_axi_wdata = '0;
      if1.s_axi_wstrb = '0; if1.s_axi_wvalid = 1'b0; if1.s_axi_bready = 1'b0;
      if3.s_axi_awaddr = '0; if3.s_axi_awvalid = 1'b0; if3.s_axi_wdata = '0;
      if3.s_axi_wstrb = '0; if3.s_axi_wvalid = 1'b0; if3.s_axi_bready = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_arready", 32'(if1.s_axi_arready), 32'd0);
      chk("rst_rvalid",  32'(if1.s_axi_rvalid),  32'd0);
      chk("rst_rdata",   if1.s_axi_rdata,        32'd0);
      chk("rst_rresp",   32'(if1.s_axi_rresp),   32'd0);
      chk("rst_arready3", 32'(if3.s_axi_arready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_arready", 32'(if1.s_axi_arready), 32'd1);

      // a=1, b=5
      read_chk("first", 1, 32'h0000_0034, 0, 1, 32'd5, 2'b00);
      read_chk("a7b7",  1, 32'h0000_00FC, 0, 1, 32'd49, 2'b00);
      read_chk("a0b6",  1, 32'h0000_0018, 0, 1, 32'd0, 2'b00);
      read_chk("a4b0",  1, 32'h0000_0080, 0, 1, 32'd0, 2'b00);
      for (int a = 0; a < 8; a++)
         for (int b = 0; b < 8; b++)
            read_chk("sweep", 1, 32'((a << 5) | (b << 2)), 0, 1, 32'(a * b), 2'b00);

      read_chk("decerr", 1, 32'h0000_0106, 0, 1, 32'd0, 2'b11);
      read_chk("slverr", 1, 32'h0000_0022, 0, 1, 32'd0, 2'b10);

      // a=3, b=6 through the slow slave with backpressure
      read_chk("lat3", 3, 32'h0000_0078, 4, 3, 32'd18, 2'b00);
      read_chk("lat3_decerr", 3, 32'h0001_0000, 1, 3, 32'd0, 2'b11);

      // Reset while the slow slave sits in RESP.
      @(negedge clk);
      drive_ar(3, 1'b1, 32'h0000_00FC);
      drive_rready(3, 1'b0);
      n = 0;
      while (!if3.s_axi_arready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      drive_ar(3, 1'b0, 32'h0);
      n = 0;
      while (!if3.s_axi_rvalid && n < 20) begin @(posedge clk); #1; n++; end
      chk("mid_rst_reached_resp", 32'(if3.s_axi_rvalid), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_rvalid",  32'(if3.s_axi_rvalid),  32'd0);
      chk("mid_rst_rdata",   if3.s_axi_rdata,        32'd0);
      chk("mid_rst_arready", 32'(if3.s_axi_arready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_arready_back", 32'(if3.s_axi_arready), 32'd1);
      chk("mid_rst_no_beat", 32'(if3.s_axi_rvalid), 32'd0);
      // a=6, b=7
      read_chk("after_rst", 3, 32'h0000_00DC, 0, 3, 32'd42, 2'b00);

`ifdef TIMES_TABLE_WRITE_RESP_EN
      if1.s_axi_bready = 1'b1;
      @(negedge clk);
      if1.s_axi_awaddr = 32'h0000_0034;
      if1.s_axi_awvalid = 1'b1;
      n = 0;
      while (!if1.s_axi_awready && n < 20) begin @(negedge clk); n++; end
      chk("aw_ready", 32'(if1.s_axi_awready), 32'd1);
      @(posedge clk); #1;
      if1.s_axi_awvalid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if1.s_axi_wdata = 32'hDEAD_BEEF;
      if1.s_axi_wstrb = 4'hF;
      if1.s_axi_wvalid = 1'b1;
      chk("w_ready", 32'(if1.s_axi_wready), 32'd1);
      chk("b_not_early", 32'(if1.s_axi_bvalid), 32'd0);
      @(posedge clk); #1;
      if1.s_axi_wvalid = 1'b0;
      chk("b_after_w_edge", 32'(if1.s_axi_bvalid), 32'd0);
      @(posedge clk); #1;
      chk("bvalid", 32'(if1.s_axi_bvalid), 32'd1);
      chk("bresp", 32'(if1.s_axi_bresp), 32'd2);
      @(posedge clk); #1;
      chk("bvalid_done", 32'(if1.s_axi_bvalid), 32'd0);
      if1.s_axi_bready = 1'b0;
      read_chk("after_write", 1, 32'h0000_0034, 0, 1, 32'd5, 2'b00);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
